// File: rtl/vec_issue_scheduler.sv
// vec_issue_scheduler
//   In-order issue stage between the scalar core and the vector datapath. Vector
//   instructions and their rs1/rs2 operands are queued in a small FIFO. One entry
//   is issued at a time. The scheduler waits for inst_done, then holds a
//   completion ack until the scalar side accepts it.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   inst_valid            scalar -> sched: instruction/operands valid
//   instruction           vector instruction word
//   rs1_data, rs2_data    scalar operands
//   vec_pro_ready         sched -> scalar: FIFO can accept (combinational)
//   flush                 discard queued entries; the in-flight entry is kept
//   issue_valid           issued instruction is stable to the datapath
//   issue_start           one-cycle pulse in the first cycle of issue_valid
//   issue_inst/rs1/rs2    issued instruction and operands
//   inst_done             datapath -> sched: completion pulse
//   vec_pro_ack           completion ack, held until scalar_pro_ready
//   scalar_pro_ready      scalar accepts the ack
//   q_count               queued entries; excludes the in-flight entry
//   busy                  an instruction is in flight or entries are queued
//   err_spurious_done     sticky: inst_done seen outside execution
module vec_issue_scheduler #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inst_valid,
    input  logic [XLEN-1:0]            instruction,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    output logic                       vec_pro_ready,
    input  logic                       flush,
    output logic                       issue_valid,
    output logic                       issue_start,
    output logic [XLEN-1:0]            issue_inst,
    output logic [XLEN-1:0]            issue_rs1,
    output logic [XLEN-1:0]            issue_rs2,
    input  logic                       inst_done,
    output logic                       vec_pro_ack,
    input  logic                       scalar_pro_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       busy,
    output logic                       err_spurious_done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            start_q;
    logic            err_q, err_d;
    logic [XLEN-1:0] inst_r_q, rs1_r_q, rs2_r_q;

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] rs1_mem  [DEPTH];
    logic [XLEN-1:0] rs2_mem  [DEPTH];

    logic push, pop, nonempty;

    assign nonempty      = (count_q != '0);
    assign vec_pro_ready = (count_q != CW'(DEPTH)) & ~flush;
    assign push          = inst_valid & vec_pro_ready;

    // Sequencing; pop is only ever raised when leaving IDLE or ACK for EXEC.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (inst_done) err_d = 1'b1;
                if (nonempty && !flush) begin
                    pop     = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (inst_done) state_d = StAck;
            end
            StAck: begin
                if (inst_done) err_d = 1'b1;
                if (scalar_pro_ready) begin
                    if (nonempty && !flush) begin
                        pop     = 1'b1;
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Queue bookkeeping; flush wins over everything. A push is never blocked by a
    // flush-suppressed pop because ready already drops during flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            inst_r_q <= '0;
            rs1_r_q  <= '0;
            rs2_r_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            start_q  <= pop;
            err_q    <= err_d;
            if (pop) begin
                inst_r_q <= inst_mem[rd_ptr_q];
                rs1_r_q  <= rs1_mem[rd_ptr_q];
                rs2_r_q  <= rs2_mem[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= instruction;
            rs1_mem[wr_ptr_q]  <= rs1_data;
            rs2_mem[wr_ptr_q]  <= rs2_data;
        end
    end

    assign issue_valid       = (state_q == StExec);
    assign issue_start       = issue_valid & start_q;
    assign issue_inst        = inst_r_q;
    assign issue_rs1         = rs1_r_q;
    assign issue_rs2         = rs2_r_q;
    assign vec_pro_ack       = (state_q == StAck);
    assign q_count           = count_q;
    assign busy              = (state_q != StIdle) | nonempty;
    assign err_spurious_done = err_q;

endmodule
